// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Holds the FSM encoding, the bus widths, the master indices, the latched
// request bundle and the watchdog width helper.
package wb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  // Master 0 is the instruction-fetch port and master 1 is the data port.
  localparam logic IMASTER = 1'b0;
  localparam logic DMASTER = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Attributes of one single-beat transfer, latched on grant.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [SEL_W-1:0]  sel;
  } wb_req_t;

  // The watchdog needs enough bits to reach the timeout value.
  // It is never narrower than one bit, even when the watchdog is disabled.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Signal bundle between the two core ports, the arbiter and bus_top.
// The slave modport is the arbiter's view of the bundle.
// The master modport is the view of whatever drives the arbiter: the core
// ports and the downstream Wishbone slave.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              m0_req;
  logic              m1_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_we;
  logic              m1_we;
  logic [SEL_W-1:0]  m0_sel;
  logic [SEL_W-1:0]  m1_sel;
  logic              m0_ack;
  logic              m1_ack;
  logic              m0_err;
  logic              m1_err;
  logic [DATA_W-1:0] m0_rdata;
  logic [DATA_W-1:0] m1_rdata;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic [DATA_W-1:0] wb_data_i;
  logic              wb_ack_i;

  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_we, m1_we, m0_sel, m1_sel, wb_data_i, wb_ack_i,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );

  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
           m0_we, m1_we, m0_sel, m1_sel, wb_data_i, wb_ack_i,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o
  );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational two-request round-robin picker.
// A lone request always wins. On a tie the master that was not granted
// last time wins.
module wb_rr_pick
  import wb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_o,
  output logic       valid_o
);

  // Choose the winning master index and flag whether anyone is asking.
  always_comb begin
    gnt_o   = IMASTER;
    valid_o = 1'b0;
    case (req_i)
      2'b01: begin
        gnt_o   = IMASTER;
        valid_o = 1'b1;
      end
      2'b10: begin
        gnt_o   = DMASTER;
        valid_o = 1'b1;
      end
      2'b11: begin
        gnt_o   = ~last_gnt_i;
        valid_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter and single-beat bus sequencer.
// It grants the fetch and data ports in round-robin order and runs one
// registered classic cycle at a time on bus_top. A watchdog aborts any
// cycle the slave never acknowledges.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int unsigned WD_W = wdog_width(TIMEOUT);

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_q, gnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              cyc_q, cyc_d;
  wb_req_t           req_q, req_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              pick_gnt;
  logic              pick_valid;
  logic              timeout_hit;
  wb_req_t           m0_attr;
  wb_req_t           m1_attr;

  assign m0_attr = {bus.m0_addr, bus.m0_wdata, bus.m0_we, bus.m0_sel};
  assign m1_attr = {bus.m1_addr, bus.m1_wdata, bus.m1_we, bus.m1_sel};

  // The watchdog fires on the edge where the count would reach TIMEOUT.
  // This keeps cyc high for exactly TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(wdog_q) + 32'd1) == TIMEOUT);

  wb_rr_pick u_pick (
    .req_i      ({bus.m1_req, bus.m0_req}),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (pick_gnt),
    .valid_o    (pick_valid)
  );

  // Next-state logic: grant in IDLE; in BUSY finish on slave ack or on watchdog expiry.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    wdog_d     = wdog_q;
    cyc_d      = cyc_q;
    req_d      = req_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = BUSY;
          gnt_d      = pick_gnt;
          last_gnt_d = pick_gnt;
          req_d      = (pick_gnt == DMASTER) ? m1_attr : m0_attr;
          cyc_d      = 1'b1;
          wdog_d     = '0;
        end
      end
      BUSY: begin
        if (bus.wb_ack_i) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          if (gnt_q == DMASTER) begin
            ack1_d   = 1'b1;
            rdata1_d = bus.wb_data_i;
          end else begin
            ack0_d   = 1'b1;
            rdata0_d = bus.wb_data_i;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          if (gnt_q == DMASTER) begin
            ack1_d   = 1'b1;
            err1_d   = 1'b1;
            rdata1_d = '0;
          end else begin
            ack0_d   = 1'b1;
            err0_d   = 1'b1;
            rdata0_d = '0;
          end
        end else if (wdog_q != {WD_W{1'b1}}) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset clears everything at once, even mid-cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= IMASTER;
      gnt_q      <= IMASTER;
      wdog_q     <= '0;
      cyc_q      <= 1'b0;
      req_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      wdog_q     <= wdog_d;
      cyc_q      <= cyc_d;
      req_q      <= req_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // cyc and stb always move together on a single-beat cycle, so one flop drives both.
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = req_q.we;
  assign bus.wb_addr_o = req_q.addr;
  assign bus.wb_data_o = req_q.wdata;
  assign bus.wb_sel_o  = req_q.sel;
  assign bus.m0_ack    = ack0_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.m0_err    = err0_q;
  assign bus.m1_err    = err1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;

endmodule
